// File: rtl/giraffe_adc_emulator.sv
// Chip-side stand-in for the Giraffe ADC: answers each adc_ena rising edge with
// four deterministic words strobed on adc_ack / adc_ack_sub.
module giraffe_adc_emulator #(
  parameter int NUM_bit      = 6,
  parameter int CONV_LATENCY = 4,
  parameter int ACK_HIGH     = 2,
  parameter int ACK_LOW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adc_rstn,
  input  logic               adc_ena,
  input  logic               adc_calib_ena,
  input  logic [8:0]         adc_NOWA,
  output logic               adc_ack,
  output logic               adc_ack_sub,
  output logic [NUM_bit-1:0] adc_dout,
  output logic               busy,
  output logic               overrun,
  output logic [17:0]        conv_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_SETUP, S_ACKH, S_ACKL} state_t;

  localparam logic [15:0]        LAT_LAST = 16'(CONV_LATENCY - 1);
  localparam logic [15:0]        HI_LAST  = 16'(ACK_HIGH - 1);
  localparam logic [15:0]        LO_LAST  = 16'(ACK_LOW - 1);
  localparam logic [NUM_bit-1:0] MID      = {1'b1, {(NUM_bit-1){1'b0}}};
  localparam logic [NUM_bit-1:0] MID_M1   = {1'b0, {(NUM_bit-1){1'b1}}};

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_cyc, w_cyc_nxt;
  logic [1:0]         r_word, w_word_nxt;
  logic               r_ena_d;
  logic               r_calib_l;
  logic [NUM_bit-1:0] r_ofs_l;
  logic [NUM_bit-1:0] r_seq, w_seq_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_ack_sub, w_ack_sub_nxt;
  logic [NUM_bit-1:0] r_dout, w_dout_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_overrun, w_overrun_nxt;
  logic [17:0]        r_conv_cnt, w_conv_cnt_nxt;
  logic               w_start, w_load, w_done;
  logic               w_unused_nowa;

  assign w_start       = adc_ena & ~r_ena_d;
  // Only the low NUM_bit bits of the offset are meaningful.
  assign w_unused_nowa = ^adc_NOWA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_word     <= '0;
      r_ena_d    <= 1'b0;
      r_calib_l  <= 1'b0;
      r_ofs_l    <= '0;
      r_seq      <= '0;
      r_ack      <= 1'b0;
      r_ack_sub  <= 1'b0;
      r_dout     <= '0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_conv_cnt <= '0;
    end else begin
      r_ena_d <= adc_ena;
      // adc_rstn low aborts synchronously; the edge detector keeps tracking.
      if (!adc_rstn) begin
        r_state    <= S_IDLE;
        r_cyc      <= '0;
        r_word     <= '0;
        r_seq      <= '0;
        r_ack      <= 1'b0;
        r_ack_sub  <= 1'b0;
        r_dout     <= '0;
        r_busy     <= 1'b0;
        r_overrun  <= 1'b0;
        r_conv_cnt <= '0;
      end else begin
        r_state    <= w_state_nxt;
        r_cyc      <= w_cyc_nxt;
        r_word     <= w_word_nxt;
        r_seq      <= w_seq_nxt;
        r_ack      <= w_ack_nxt;
        r_ack_sub  <= w_ack_sub_nxt;
        r_dout     <= w_dout_nxt;
        r_busy     <= w_busy_nxt;
        r_overrun  <= w_overrun_nxt;
        r_conv_cnt <= w_conv_cnt_nxt;
        if (r_state == S_IDLE && w_start) begin
          r_calib_l <= adc_calib_ena;
          r_ofs_l   <= adc_NOWA[NUM_bit-1:0];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc + 16'd1;
    w_word_nxt  = r_word;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cyc_nxt = '0;
        if (w_start) begin
          w_state_nxt = S_CONV;
          w_word_nxt  = 2'd0;
        end
      end
      S_CONV: begin
        if (r_cyc == LAT_LAST) begin
          w_state_nxt = S_SETUP;
          w_cyc_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACKH;
        w_cyc_nxt   = '0;
      end
      S_ACKH: begin
        if (r_cyc == HI_LAST) begin
          w_state_nxt = S_ACKL;
          w_cyc_nxt   = '0;
        end
      end
      S_ACKL: begin
        if (r_cyc == LO_LAST) begin
          w_cyc_nxt = '0;
          if (r_word != 2'd3) begin
            w_word_nxt  = r_word + 2'd1;
            w_state_nxt = S_SETUP;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state and registered, so nothing is combinational to the pins.
  always_comb begin
    w_ack_nxt      = (w_state_nxt == S_ACKH) && (w_word_nxt == 2'd0);
    w_ack_sub_nxt  = (w_state_nxt == S_ACKH) && (w_word_nxt != 2'd0);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_dout_nxt     = r_dout;
    w_seq_nxt      = r_seq;
    w_conv_cnt_nxt = w_done ? r_conv_cnt + 18'd1 : r_conv_cnt;
    w_overrun_nxt  = r_overrun | (w_start && (r_state != S_IDLE));
    if (w_load) begin
      if (r_calib_l) begin
        w_dout_nxt = w_word_nxt[0] ? MID_M1 : MID;
      end else begin
        w_dout_nxt = r_seq + r_ofs_l;
        w_seq_nxt  = r_seq + {{(NUM_bit-1){1'b0}}, 1'b1};
      end
    end
  end

  assign adc_ack     = r_ack;
  assign adc_ack_sub = r_ack_sub;
  assign adc_dout    = r_dout;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign conv_cnt    = r_conv_cnt;

endmodule

// File: tb/tb_giraffe_adc_emulator.sv
// Directed self-checking bench for giraffe_adc_emulator at default parameters.
module tb_giraffe_adc_emulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_rstn = 1'b1;
  logic        adc_ena = 1'b0;
  logic        adc_calib_ena = 1'b0;
  logic [8:0]  adc_NOWA = '0;
  logic        adc_ack, adc_ack_sub, busy, overrun;
  logic [5:0]  adc_dout;
  logic [17:0] conv_cnt;

  int checks = 0;
  int failures = 0;

  // Per-edge trace of one conversion; index e = value just after edge E(e).
  logic [24:0] ackVec, subVec, busyVec;
  logic [5:0]  doutTr [0:24];

  localparam logic [24:0] EXP_ACK  = 25'h0000060;
  localparam logic [24:0] EXP_SUB  = 25'h0318C00;
  localparam logic [24:0] EXP_BUSY = 25'h0FFFFFF;

  always #5 clk = ~clk;

  giraffe_adc_emulator dut (
    .clk(clk), .rst(rst), .adc_rstn(adc_rstn), .adc_ena(adc_ena),
    .adc_calib_ena(adc_calib_ena), .adc_NOWA(adc_NOWA),
    .adc_ack(adc_ack), .adc_ack_sub(adc_ack_sub), .adc_dout(adc_dout),
    .busy(busy), .overrun(overrun), .conv_cnt(conv_cnt)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic recordEdge(input int e);
    ackVec[e]  = adc_ack;
    subVec[e]  = adc_ack_sub;
    busyVec[e] = busy;
    doutTr[e]  = adc_dout;
  endtask

  // Start at E0 and trace through E24; an optional extra pulse lands on edge pulseAt.
  task automatic applyStimulus(input logic calib, input logic [8:0] nowa, input int pulseAt);
    adc_calib_ena = calib;
    adc_NOWA = nowa;
    adc_ena = 1'b1;
    tick();
    recordEdge(0);
    for (int e = 1; e <= 24; e++) begin
      adc_ena = (e == pulseAt);
      tick();
      recordEdge(e);
    end
    adc_ena = 1'b0;
  endtask

  function automatic logic [23:0] wordsSeen();
    return {doutTr[4], doutTr[9], doutTr[14], doutTr[19]};
  endfunction

  task automatic checkConv(input string tag, input logic [23:0] expWords);
    checkOutput({tag, "_words"}, {8'd0, wordsSeen()}, {8'd0, expWords});
    checkOutput({tag, "_ack"}, {7'd0, ackVec}, {7'd0, EXP_ACK});
    checkOutput({tag, "_sub"}, {7'd0, subVec}, {7'd0, EXP_SUB});
    checkOutput({tag, "_busy"}, {7'd0, busyVec}, {7'd0, EXP_BUSY});
  endtask

  initial begin
    logic [5:0] b;
    logic anyBusy, anyStrobe;

    // Reset state
    tick();
    checkOutput("rst_ack", {31'd0, adc_ack}, 32'd0);
    checkOutput("rst_sub", {31'd0, adc_ack_sub}, 32'd0);
    checkOutput("rst_dout", {26'd0, adc_dout}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ovr", {31'd0, overrun}, 32'd0);
    checkOutput("rst_cnt", {14'd0, conv_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Normal conversion with offset 5
    applyStimulus(1'b0, 9'd5, 0);
    checkConv("norm", {6'd5, 6'd6, 6'd7, 6'd8});
    checkOutput("norm_cnt", {14'd0, conv_cnt}, 32'd1);
    checkOutput("norm_ovr", {31'd0, overrun}, 32'd0);

    // Fresh reset, then 17 back-to-back conversions at 25-cycle spacing
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    for (int i = 0; i <= 16; i++) begin
      applyStimulus(1'b0, 9'd0, 0);
      b = 6'(4 * i);
      checkOutput($sformatf("wrap%0d_words", i), {8'd0, wordsSeen()},
                  {8'd0, b, b + 6'd1, b + 6'd2, b + 6'd3});
      if (i == 15) checkOutput("wrap_last63", {26'd0, doutTr[19]}, 32'd63);
    end
    checkConv("wrap17", {6'd0, 6'd1, 6'd2, 6'd3});
    checkOutput("wrap_ovr", {31'd0, overrun}, 32'd0);
    checkOutput("wrap_cnt", {14'd0, conv_cnt}, 32'd17);

    // Calibration pattern leaves seq (now 4) untouched
    applyStimulus(1'b1, 9'd0, 0);
    checkConv("calib", {6'd32, 6'd31, 6'd32, 6'd31});
    applyStimulus(1'b0, 9'd0, 0);
    checkConv("postcal", {6'd4, 6'd5, 6'd6, 6'd7});
    checkOutput("postcal_cnt", {14'd0, conv_cnt}, 32'd19);

    // Second rising edge 10 cycles into a conversion
    applyStimulus(1'b0, 9'd0, 10);
    checkConv("ovr", {6'd8, 6'd9, 6'd10, 6'd11});
    checkOutput("ovr_flag", {31'd0, overrun}, 32'd1);
    checkOutput("ovr_cnt", {14'd0, conv_cnt}, 32'd20);
    tick();
    tick();
    checkOutput("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Abort during CONV with adc_ena held high across release
    adc_NOWA = 9'd3;
    adc_ena = 1'b1;
    tick();
    checkOutput("abort_busy0", {31'd0, busy}, 32'd1);
    tick();
    adc_rstn = 1'b0;
    tick();
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_dout", {26'd0, adc_dout}, 32'd0);
    checkOutput("abort_cnt", {14'd0, conv_cnt}, 32'd0);
    checkOutput("abort_ovr", {31'd0, overrun}, 32'd0);
    tick();
    tick();
    adc_rstn = 1'b1;
    anyBusy = 1'b0;
    anyStrobe = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      anyBusy |= busy;
      anyStrobe |= adc_ack | adc_ack_sub;
    end
    checkOutput("abort_nostart", {31'd0, anyBusy}, 32'd0);
    checkOutput("abort_nostrobe", {31'd0, anyStrobe}, 32'd0);
    adc_ena = 1'b0;
    tick();
    applyStimulus(1'b0, 9'd3, 0);
    checkConv("postabort", {6'd3, 6'd4, 6'd5, 6'd6});
    checkOutput("postabort_cnt", {14'd0, conv_cnt}, 32'd1);

    // Asynchronous reset in the middle of word 2's strobe
    adc_NOWA = 9'd0;
    adc_ena = 1'b1;
    tick();
    adc_ena = 1'b0;
    for (int e = 1; e <= 15; e++) tick();
    checkOutput("ar_pre_sub", {31'd0, adc_ack_sub}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("ar_sub", {31'd0, adc_ack_sub}, 32'd0);
    checkOutput("ar_ack", {31'd0, adc_ack}, 32'd0);
    checkOutput("ar_dout", {26'd0, adc_dout}, 32'd0);
    checkOutput("ar_busy", {31'd0, busy}, 32'd0);
    checkOutput("ar_cnt", {14'd0, conv_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    checkOutput("ar_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
